pwm_gen_core: RTL and testbench
===============================

# pwm_gen_core

PWM generation core that sits directly downstream of the AXI4-Lite register slave in the PWM controller IP. It consumes the four 32-bit slave registers (control, period, duty, prescale) and produces one PWM output pin, a period-done pulse and readback status. Period, duty and prescale are double-buffered, so a register write never glitches the period in progress.

## Interface
- CNT_WIDTH, 32: width of period, duty, prescale and counters.
- ACLK  in  1  clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- ctrl_reg  in  32  slave reg0. bit0 enable, bit1 invert, bit2 graceful_stop, bit3 one_shot; other bits ignored.
- period_reg  in  CNT_WIDTH  slave reg1, period P in ticks.
- duty_reg  in  CNT_WIDTH  slave reg2, active ticks D per period.
- prescale_reg  in  CNT_WIDTH  slave reg3; tick every prescale+1 clocks.
- pwm_out  out  1  registered PWM pin.
- period_done  out  1  one-cycle pulse at each period end.
- busy  out  1  high when state is not IDLE.
- cnt_out  out  CNT_WIDTH  current period counter, for slave readback.

## Operation
- Clock and reset: one clock, ACLK; ARESET is synchronous and active-high.
- States: IDLE, RUN, DRAIN.
- Shadow registers sh_P, sh_D and sh_pre load from the inputs on IDLE->RUN and on every period wrap. If period_reg = 0, sh_P loads as 1.
- Prescaler:
  - pcnt counts 0..sh_pre.
  - tick is asserted when pcnt == sh_pre; pcnt then returns to 0.
  - pcnt and cnt are both cleared on IDLE->RUN.
- Counter:
  - On a tick, cnt advances 0..sh_P-1, then wraps to 0.
  - The wrap cycle pulses period_done and reloads the shadows.
- Active level:
  - active = (cnt < sh_D); D >= P gives 100 % duty, D = 0 gives 0 %.
  - pwm_out = active XOR invert in RUN and DRAIN, and invert in IDLE.
  - invert is not shadowed; it takes effect on the next clock.
- armed flag:
  - Set at reset and whenever enable = 0 is sampled.
  - Cleared when a one_shot period completes.
- Transitions:
  - IDLE->RUN when enable = 1 and armed = 1.
  - RUN->IDLE when enable = 0 and graceful_stop = 0. The stop is immediate; no period_done is issued.
  - RUN->DRAIN when enable = 0 and graceful_stop = 1.
  - DRAIN->RUN when enable returns to 1. Counting continues uninterrupted.
  - DRAIN->IDLE on the wrap cycle. period_done is still pulsed.
  - RUN->IDLE on the wrap cycle when one_shot = 1. armed clears, so restarting requires enable to drop to 0 and return to 1.
- Simultaneous events:
  - Wrap takes priority over the stop decision in the same cycle, so period_done is emitted.
  - A register change on the wrap cycle is captured by the shadows.
- Widths:
  - All comparisons are unsigned CNT_WIDTH.
  - cnt never exceeds sh_P-1; there is no overflow path.

## Timing
- Reset: state = IDLE, pcnt = cnt = 0, sh_P = 1, sh_D = 0, sh_pre = 0, armed = 1.
- Reset outputs: pwm_out = 0, period_done = 0, busy = 0, cnt_out = 0.
- Reset asserted mid-run returns to these values on the next edge, whatever the state.
- Start latency: enable sampled at edge N means that at N+1 state = RUN, busy = 1 and cnt = 0.
- At N+1, pwm_out = (0 < D) XOR invert. pwm_out is registered from next-state values.
- With prescale = 0, cnt advances every clock, so a period lasts P clocks; with prescale k it lasts P(k+1) clocks.
- period_done and the shadow reload occur in the same cycle as cnt returning to 0. The new duty applies starting that cycle.
- Immediate stop: at the edge after enable = 0 is sampled, pwm_out = invert and busy = 0.
- No combinational paths from inputs to outputs.

## Test plan
- P = 10, D = 3, pre = 0, enable set -> pwm_out high 3 clocks, low 7, repeating; period_done every 10 clocks, coincident with cnt_out = 0.
- Running at P = 10, D = 3, write D = 7 at cnt = 5 -> current period stays 3 high; the next period starts 7 high. Then set pre = 1 -> after the next wrap, period = 20 clocks.
- D = 0 -> pwm_out constantly 0; D = 15 with P = 10 -> constantly 1. Set invert = 1 -> both levels flip the next clock, including the IDLE level.
- Graceful stop at cnt = 4 (P = 10) -> 6 more periods' ticks, period_done, then busy = 0. The same case with graceful_stop = 0 -> busy = 0 the next clock, with no period_done.
- one_shot = 1, enable held at 1 -> exactly one period and one period_done, then IDLE. Drop enable to 0 and raise it again -> exactly one more period.
- ARESET asserted at cnt = 6 in RUN -> next clock all outputs are at reset values. Release with enable still 1 -> restart at cnt = 0 one clock later.

Source files
------------

// File: rtl/pwm_gen_core.sv
// PWM generator behind the AXI4-Lite register slave.
// Period, duty and prescale are double-buffered and reload at each period wrap.
module pwm_gen_core #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ctrl_reg,
    input  logic [CNT_WIDTH-1:0] period_reg,
    input  logic [CNT_WIDTH-1:0] duty_reg,
    input  logic [CNT_WIDTH-1:0] prescale_reg,
    output logic                 pwm_out,
    output logic                 period_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] sh_p_q, sh_p_d;
    logic [CNT_WIDTH-1:0] sh_d_q, sh_d_d;
    logic [CNT_WIDTH-1:0] sh_pre_q, sh_pre_d;
    logic                 armed_q, armed_d;
    logic                 pwm_q, pwm_d;
    logic                 done_q, done_d;

    logic enable, invert, graceful, one_shot;
    logic tick, last, wrap, load;
    logic unused_ctrl;

    assign enable      = ctrl_reg[0];
    assign invert      = ctrl_reg[1];
    assign graceful    = ctrl_reg[2];
    assign one_shot    = ctrl_reg[3];
    assign unused_ctrl = ^ctrl_reg[31:4];

    assign tick = (pcnt_q == sh_pre_q);
    assign last = (cnt_q == sh_p_q - ONE);
    assign wrap = (state_q != IDLE) && tick && last;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        cnt_d    = cnt_q;
        sh_p_d   = sh_p_q;
        sh_d_d   = sh_d_q;
        sh_pre_d = sh_pre_q;
        armed_d  = armed_q;
        done_d   = 1'b0;
        load     = 1'b0;
        pwm_d    = invert;

        unique case (state_q)
            IDLE: begin
                if (enable && armed_q) begin
                    state_d = RUN;
                    load    = 1'b1;
                    pcnt_d  = ZERO;
                    cnt_d   = ZERO;
                end
            end
            RUN, DRAIN: begin
                pcnt_d = tick ? ZERO : pcnt_q + ONE;
                if (tick) begin
                    cnt_d = last ? ZERO : cnt_q + ONE;
                end
                // The wrap outranks any stop request so period_done still fires
                if (wrap) begin
                    done_d = 1'b1;
                    load   = 1'b1;
                    if (state_q == DRAIN) begin
                        state_d = enable ? RUN : IDLE;
                    end else if (!enable || one_shot) begin
                        state_d = IDLE;
                    end
                    if (state_q == RUN && enable && one_shot) begin
                        armed_d = 1'b0;
                    end
                end else if (state_q == RUN && !enable) begin
                    state_d = graceful ? DRAIN : IDLE;
                end else if (state_q == DRAIN && enable) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sh_p_d   = (period_reg == ZERO) ? ONE : period_reg;
            sh_d_d   = duty_reg;
            sh_pre_d = prescale_reg;
        end
        if (state_d == IDLE) begin
            pcnt_d = ZERO;
            cnt_d  = ZERO;
        end
        if (!enable) begin
            armed_d = 1'b1;
        end
        if (state_d != IDLE) begin
            pwm_d = (cnt_d < sh_d_d) ^ invert;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            pcnt_q   <= ZERO;
            cnt_q    <= ZERO;
            sh_p_q   <= ONE;
            sh_d_q   <= ZERO;
            sh_pre_q <= ZERO;
            armed_q  <= 1'b1;
            pwm_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
            sh_p_q   <= sh_p_d;
            sh_d_q   <= sh_d_d;
            sh_pre_q <= sh_pre_d;
            armed_q  <= armed_d;
            pwm_q    <= pwm_d;
            done_q   <= done_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = done_q;
    assign busy        = (state_q != IDLE);
    assign cnt_out     = cnt_q;

endmodule

// File: tb/tb_pwm_gen_core.sv
// Bench for pwm_gen_core: directed table, corner sequences and
// randomized lockstep comparison against an elapsed-time model.
module tb_pwm_gen_core;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] ctrl_reg, period_reg, duty_reg, prescale_reg;
    logic        pwm_out, period_done, busy;
    logic [31:0] cnt_out;

    pwm_gen_core #(.CNT_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ctrl_reg(ctrl_reg),
        .period_reg(period_reg), .duty_reg(duty_reg),
        .prescale_reg(prescale_reg), .pwm_out(pwm_out),
        .period_done(period_done), .busy(busy), .cnt_out(cnt_out)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the period is tracked as clocks elapsed since
    // the period began; cnt and the wrap follow by division.
    int     m_mode;
    longint m_el, m_p, m_d, m_pre;
    bit     m_armed;
    bit     e_pwm, e_pd, e_busy;
    longint e_cnt;

    task automatic model_load();
        m_p   = (period_reg == 0) ? 1 : longint'(period_reg);
        m_d   = longint'(duty_reg);
        m_pre = longint'(prescale_reg);
    endtask

    task automatic model_step();
        bit en, inv, gs, os;
        en  = ctrl_reg[0];
        inv = ctrl_reg[1];
        gs  = ctrl_reg[2];
        os  = ctrl_reg[3];
        if (ARESET) begin
            m_mode = 0; m_el = 0; m_p = 1; m_d = 0; m_pre = 0;
            m_armed = 1;
            e_pwm = 0; e_pd = 0; e_busy = 0; e_cnt = 0;
            return;
        end
        e_pd = 0;
        if (m_mode == 0) begin
            if (en && m_armed) begin
                model_load();
                m_el = 0;
                m_mode = 1;
            end
        end else begin
            m_el++;
            if (m_el == m_p * (m_pre + 1)) begin
                e_pd = 1;
                m_el = 0;
                model_load();
                if (m_mode == 2) m_mode = en ? 1 : 0;
                else if (!en || os) begin
                    if (en) m_armed = 0;
                    m_mode = 0;
                end
            end else if (m_mode == 1 && !en) m_mode = gs ? 2 : 0;
            else if (m_mode == 2 && en) m_mode = 1;
        end
        if (!en) m_armed = 1;
        if (m_mode == 0) m_el = 0;
        e_cnt  = (m_mode == 0) ? 0 : m_el / (m_pre + 1);
        e_busy = (m_mode != 0);
        e_pwm  = (m_mode == 0) ? inv : ((e_cnt < m_d) ^ inv);
    endtask

    task automatic cyc();
        @(posedge ACLK);
        model_step();
        @(negedge ACLK);
        check("model pwm_out", {63'd0, pwm_out}, {63'd0, e_pwm});
        check("model period_done", {63'd0, period_done}, {63'd0, e_pd});
        check("model busy", {63'd0, busy}, {63'd0, e_busy});
        check("model cnt_out", {32'd0, cnt_out}, e_cnt);
    endtask

    task automatic do_reset();
        ctrl_reg = 0;
        ARESET = 1;
        cyc();
        ARESET = 0;
    endtask

    task automatic set_regs(input int p, input int d, input int pre);
        period_reg = p;
        duty_reg = d;
        prescale_reg = pre;
    endtask

    task automatic wait_pd();
        int n = 0;
        while (!period_done && n < 400) begin
            cyc();
            n++;
        end
        check("wait period_done", {63'd0, period_done}, 64'd1);
    endtask

    task automatic measure(output int len, output int high);
        len = 0;
        high = 0;
        do begin
            high += int'(pwm_out);
            len++;
            cyc();
        end while (!period_done && len < 400);
    endtask

    typedef struct {
        int p, d, pre;
        bit inv;
        int len, high;
    } vec_t;

    vec_t vt[8];

    initial begin
        int len, high, h, n, c;
        vt[0] = '{10, 3, 0, 0, 10, 3};
        vt[1] = '{10, 0, 0, 0, 10, 0};
        vt[2] = '{10, 15, 0, 0, 10, 10};
        vt[3] = '{10, 3, 1, 0, 20, 6};
        vt[4] = '{0, 5, 0, 0, 1, 1};
        vt[5] = '{10, 3, 0, 1, 10, 7};
        vt[6] = '{4, 4, 2, 0, 12, 12};
        vt[7] = '{5, 2, 3, 0, 20, 8};

        ARESET = 1;
        ctrl_reg = 0;
        set_regs(10, 3, 0);
        do_reset();
        check("reset pwm_out", {63'd0, pwm_out}, 64'd0);
        check("reset period_done", {63'd0, period_done}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset cnt_out", {32'd0, cnt_out}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_regs(vt[i].p, vt[i].d, vt[i].pre);
            ctrl_reg = {30'd0, vt[i].inv, 1'b1};
            cyc();
            check("start busy", {63'd0, busy}, 64'd1);
            check("start cnt", {32'd0, cnt_out}, 64'd0);
            wait_pd();
            measure(len, high);
            check($sformatf("vec%0d length", i), len, vt[i].len);
            check($sformatf("vec%0d high", i), high, vt[i].high);
        end

        do_reset();
        set_regs(10, 3, 0);
        ctrl_reg = 1;
        cyc();
        wait_pd();
        h = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) duty_reg = 7;
            h += int'(pwm_out);
            if (i < 9) cyc();
        end
        check("duty change old period high", h, 3);
        cyc();
        check("duty change wrap", {63'd0, period_done}, 64'd1);
        measure(len, high);
        check("new duty high", high, 7);
        prescale_reg = 1;
        measure(len, high);
        check("pre pending length", len, 10);
        measure(len, high);
        check("pre=1 length", len, 20);
        check("pre=1 high", high, 14);

        do_reset();
        set_regs(10, 0, 0);
        ctrl_reg = 1;
        repeat (3) cyc();
        check("duty0 pwm", {63'd0, pwm_out}, 64'd0);
        ctrl_reg = 3;
        cyc();
        check("duty0 inverted pwm", {63'd0, pwm_out}, 64'd1);
        duty_reg = 15;
        repeat (12) cyc();
        check("full duty inverted pwm", {63'd0, pwm_out}, 64'd0);
        ctrl_reg = 2;
        cyc();
        check("idle inverted busy", {63'd0, busy}, 64'd0);
        check("idle inverted pwm", {63'd0, pwm_out}, 64'd1);
        ctrl_reg = 0;
        cyc();
        check("idle pwm", {63'd0, pwm_out}, 64'd0);

        do_reset();
        set_regs(10, 3, 0);
        ctrl_reg = 5;
        cyc();
        wait_pd();
        repeat (4) cyc();
        check("drain start cnt", {32'd0, cnt_out}, 64'd4);
        ctrl_reg = 4;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!period_done && n < 50);
        check("drain clocks to done", n, 6);
        check("drain busy after", {63'd0, busy}, 64'd0);

        do_reset();
        ctrl_reg = 1;
        cyc();
        wait_pd();
        repeat (4) cyc();
        ctrl_reg = 0;
        cyc();
        check("stop busy", {63'd0, busy}, 64'd0);
        check("stop period_done", {63'd0, period_done}, 64'd0);
        check("stop pwm", {63'd0, pwm_out}, 64'd0);

        do_reset();
        ctrl_reg = 9;
        c = 0;
        repeat (40) begin
            cyc();
            c += int'(period_done);
        end
        check("one_shot done count", c, 1);
        check("one_shot busy", {63'd0, busy}, 64'd0);
        ctrl_reg = 0;
        cyc();
        ctrl_reg = 9;
        c = 0;
        repeat (40) begin
            cyc();
            c += int'(period_done);
        end
        check("one_shot rearm count", c, 1);

        do_reset();
        ctrl_reg = 1;
        cyc();
        n = 0;
        while (cnt_out != 6 && n < 50) begin
            cyc();
            n++;
        end
        check("reach cnt 6", {32'd0, cnt_out}, 64'd6);
        ARESET = 1;
        cyc();
        check("midreset pwm", {63'd0, pwm_out}, 64'd0);
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset cnt", {32'd0, cnt_out}, 64'd0);
        check("midreset done", {63'd0, period_done}, 64'd0);
        ARESET = 0;
        cyc();
        check("restart busy", {63'd0, busy}, 64'd1);
        check("restart cnt", {32'd0, cnt_out}, 64'd0);
        check("restart pwm", {63'd0, pwm_out}, 64'd1);

        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0)
                set_regs($urandom_range(0, 6), $urandom_range(0, 8),
                         $urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                ctrl_reg = $urandom & 32'hFFFF_FFF0;
                ctrl_reg[0] = ($urandom_range(0, 9) < 8);
                ctrl_reg[1] = $urandom_range(0, 1);
                ctrl_reg[2] = $urandom_range(0, 1);
                ctrl_reg[3] = ($urandom_range(0, 4) == 0);
            end
            ARESET = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
